// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared state encoding and sizing constants for mult_div
package mult_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_STEPS = MD_WIDTH;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on unsigned magnitudes
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

    // The remainder stays below the divisor, so a successful trial always fits WIDTH bits.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        fits     = (shifted >= {1'b0, dvs});
        trial    = shifted[WIDTH-1:0] - dvs;
        rem_next = fits ? trial : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mult_div.sv
// rtl/mult_div.sv - iterative Booth multiply / restoring divide with HI/LO results
// Optional MULTDIV_UNSIGNED_EN adds the UnsignedOp port for unsigned operations.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             UnsignedOp,
`endif
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             multStop,
    output logic             DivStop,
    output logic             DivZero
);

`ifdef MULTDIV_UNSIGNED_EN
    localparam int CNT_W = $clog2(WIDTH + 1);
`else
    localparam int CNT_W = $clog2(WIDTH);
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic [WIDTH:0]   m;
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic             dz;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             mult_stop_r;
    logic             div_stop_r;
    logic             div_zero_r;
    logic             uns_r;
    logic             uns_in;

    logic [WIDTH:0]   bsum;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;

`ifdef MULTDIV_UNSIGNED_EN
    assign uns_in = UnsignedOp;
`else
    assign uns_in = 1'b0;
    assign uns_r  = 1'b0;
`endif

    always_comb begin
        case ({q[0], qm1})
            2'b01:   bsum = acc + m;
            2'b10:   bsum = acc - m;
            default: bsum = acc;
        endcase
        a_mag = (!uns_in && A[WIDTH-1]) ? -A : A;
        b_mag = (!uns_in && B[WIDTH-1]) ? -B : B;
    end

    // Remainder lives in acc and quotient in q while dividing, reusing the Booth registers.
    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (acc[WIDTH-1:0]),
        .quo      (q),
        .dvs      (m[WIDTH-1:0]),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            q           <= '0;
            qm1         <= 1'b0;
            m           <= '0;
            is_div      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dz          <= 1'b0;
            hi_r        <= '0;
            lo_r        <= '0;
            mult_stop_r <= 1'b0;
            div_stop_r  <= 1'b0;
            div_zero_r  <= 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
            uns_r       <= 1'b0;
`endif
        end else begin
            mult_stop_r <= 1'b0;
            div_stop_r  <= 1'b0;
            div_zero_r  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    acc <= '0;
                    qm1 <= 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
                    if (MultCtrl || DivCtrl)
                        uns_r <= UnsignedOp;
`endif
                    if (MultCtrl) begin
                        is_div <= 1'b0;
                        m      <= {(A[WIDTH-1] & ~uns_in), A};
                        q      <= B;
                        state  <= MULT;
                    end else if (DivCtrl) begin
                        is_div <= 1'b1;
                        sign_a <= A[WIDTH-1];
                        sign_b <= B[WIDTH-1];
                        m      <= {1'b0, b_mag};
                        q      <= a_mag;
                        if (B == '0) begin
                            dz    <= 1'b1;
                            state <= DONE;
                        end else begin
                            dz    <= 1'b0;
                            state <= DIV;
                        end
                    end
                end
                MULT: begin
`ifdef MULTDIV_UNSIGNED_EN
                    // Extra unsigned step: the zero-extended multiplier's top pair is (0, q-1), add only.
                    if (uns_r && cnt == CNT_W'(WIDTH)) begin
                        if (qm1)
                            acc <= acc + m;
                        state <= FIX;
                    end else
`endif
                    begin
                        acc <= {bsum[WIDTH], bsum[WIDTH:1]};
                        q   <= {bsum[0], q[WIDTH-1:1]};
                        qm1 <= q[0];
                        cnt <= cnt + CNT_W'(1);
                        if (!uns_r && cnt == LAST)
                            state <= FIX;
                    end
                end
                DIV: begin
                    acc <= {1'b0, rem_n};
                    q   <= quo_n;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST)
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo_r <= (uns_r || !(sign_a ^ sign_b)) ? q : -q;
                        hi_r <= (uns_r || !sign_a) ? acc[WIDTH-1:0] : -acc[WIDTH-1:0];
                    end else begin
                        hi_r <= acc[WIDTH-1:0];
                        lo_r <= q;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (is_div) begin
                        div_stop_r <= 1'b1;
                        div_zero_r <= dz;
                    end else begin
                        mult_stop_r <= 1'b1;
                    end
                    dz    <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign HI       = hi_r;
    assign LO       = lo_r;
    assign multStop = mult_stop_r;
    assign DivStop  = div_stop_r;
    assign DivZero  = div_zero_r;

endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - directed self-checking bench for mult_div
module tb_mult_div;
    import mult_div_pkg::*;

    localparam int W   = 32;
    localparam int LAT = MD_STEPS + 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         MultCtrl = 1'b0;
    logic         DivCtrl = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic         multStop;
    logic         DivStop;
    logic         DivZero;

    int checks = 0;
    int errors = 0;
    int m_edge, m_cnt, d_edge, d_cnt, z_edge, z_cnt;
    logic [W-1:0] hi_prev, lo_prev;

    mult_div #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .MultCtrl (MultCtrl),
        .DivCtrl  (DivCtrl),
        .A        (A),
        .B        (B),
`ifdef MULTDIV_UNSIGNED_EN
        .UnsignedOp (1'b0),
`endif
        .HI       (HI),
        .LO       (LO),
        .multStop (multStop),
        .DivStop  (DivStop),
        .DivZero  (DivZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, then watch 40 edges recording where each pulse first appears.
    task automatic run_op(input logic mc, input logic dc, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int poke);
        A = a;
        B = b;
        MultCtrl = mc;
        DivCtrl = dc;
        @(posedge clk);
        #1;
        MultCtrl = 1'b0;
        DivCtrl = 1'b0;
        m_edge = -1; d_edge = -1; z_edge = -1;
        m_cnt = 0; d_cnt = 0; z_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            DivCtrl = (k == poke);
            if (multStop) begin m_cnt++; if (m_edge < 0) m_edge = k; end
            if (DivStop)  begin d_cnt++; if (d_edge < 0) d_edge = k; end
            if (DivZero)  begin z_cnt++; if (z_edge < 0) z_edge = k; end
        end
        DivCtrl = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", HI, '0);
        check("rst_lo", LO, '0);
        check("rst_mstop", {31'b0, multStop}, 32'd0);
        check("rst_dstop", {31'b0, DivStop}, 32'd0);
        check("rst_dzero", {31'b0, DivZero}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(1'b1, 1'b0, 32'd7, -32'sd3, 0);
        check("m7x-3_hi", HI, 32'hFFFF_FFFF);
        check("m7x-3_lo", LO, 32'hFFFF_FFEB);
        check("m7x-3_edge", m_edge, LAT);
        check("m7x-3_npulse", m_cnt, 32'd1);
        check("m7x-3_nodiv", d_cnt, 32'd0);

        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        check("mmin2_hi", HI, 32'h4000_0000);
        check("mmin2_lo", LO, 32'h0000_0000);

        run_op(1'b0, 1'b1, -32'sd7, 32'd2, 0);
        check("d-7/2_lo", LO, 32'hFFFF_FFFD);
        check("d-7/2_hi", HI, 32'hFFFF_FFFF);
        check("d-7/2_edge", d_edge, LAT);
        check("d-7/2_zero", z_cnt, 32'd0);

        run_op(1'b0, 1'b1, 32'd100, -32'sd7, 0);
        check("d100/-7_lo", LO, 32'hFFFF_FFF2);
        check("d100/-7_hi", HI, 32'd2);

        hi_prev = HI;
        lo_prev = LO;
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 0);
        check("d5/0_stop_edge", d_edge, 32'd1);
        check("d5/0_zero_edge", z_edge, 32'd1);
        check("d5/0_stop_cnt", d_cnt, 32'd1);
        check("d5/0_zero_cnt", z_cnt, 32'd1);
        check("d5/0_hi_hold", HI, hi_prev);
        check("d5/0_lo_hold", LO, lo_prev);

        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("dmin/-1_lo", LO, 32'h8000_0000);
        check("dmin/-1_hi", HI, 32'h0000_0000);

        A = 32'd9;
        B = 32'd9;
        MultCtrl = 1'b1;
        @(posedge clk);
        #1;
        MultCtrl = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rmid_hi", HI, '0);
        check("rmid_lo", LO, '0);
        check("rmid_mstop", {31'b0, multStop}, 32'd0);
        check("rmid_dstop", {31'b0, DivStop}, 32'd0);
        check("rmid_dzero", {31'b0, DivZero}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_op(1'b1, 1'b0, 32'd3, 32'd4, 0);
        check("m3x4_lo", LO, 32'd12);
        check("m3x4_hi", HI, 32'd0);

        run_op(1'b1, 1'b1, 32'd6, 32'd3, 5);
        check("both_lo", LO, 32'd18);
        check("both_hi", HI, 32'd0);
        check("both_medge", m_edge, LAT);
        check("both_mcnt", m_cnt, 32'd1);
        check("both_nodiv", d_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
